ready_valid_to_axi_master: RTL and testbench
============================================

// Module: ready_valid_to_axi_master
// PURPOSE
//  AXI4-Lite initiator driven by a ready/valid command/response interface; the counterpart of the AXI-Lite-to-ready/valid slave bridge.
//  User logic issues single read or write commands; the block runs one AXI-Lite transaction per command and returns data and status on a response channel.
//  At most one transaction is outstanding. It sits between PL control logic and any AXI-Lite register slave.
// PARAMETERS
//  ADDR_W   4    AXI address width (byte address)
//  DATA_W   32   AXI data width; WSTRB width is DATA_W/8
// PORTS
//  M00_AXI_aclk     in   1         clock; all logic on rising edge
//  M00_AXI_aresetn  in   1         reset, asynchronous, active-low
//  cmd_valid_i      in   1         command valid
//  cmd_ready_o      out  1         command accepted when valid&ready
//  cmd_write_i      in   1         1=write, 0=read
//  cmd_addr_i       in   ADDR_W    target address
//  cmd_wdata_i      in   DATA_W    write data (ignored for reads)
//  rsp_valid_o      out  1         response valid
//  rsp_ready_i      in   1         response consumed when valid&ready
//  rsp_rdata_o      out  DATA_W    read data; 0 for writes
//  rsp_error_o      out  1         1 when BRESP/RRESP[1]==1 (SLVERR/DECERR)
//  M00_AXI_awaddr/awvalid/awready  out/out/in  ADDR_W/1/1   write address channel
//  M00_AXI_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_W/DATA_W/8/1/1   write data channel; wstrb all ones
//  M00_AXI_bresp/bvalid/bready     in/in/out   2/1/1        write response channel
//  M00_AXI_araddr/arvalid/arready  out/out/in  ADDR_W/1/1   read address channel
//  M00_AXI_rdata/rresp/rvalid/rready  in/in/in/out  DATA_W/2/1/1   read data channel
// BEHAVIOUR
//  Reset: state IDLE; awvalid, wvalid, bready, arvalid, rready, rsp_valid_o, rsp_error_o = 0; rsp_rdata_o = 0; addr/wdata regs = 0.
//   cmd_ready_o = 0 while reset is asserted. Reset mid-transaction drops all valids immediately and discards the transaction; no response is issued.
//  All AXI outputs are registered; cmd_ready_o = (state==IDLE) (registered state, no combinational path from AXI inputs).
//  FSM:
//   IDLE: cmd handshake at edge N -> latch addr/wdata. Write: go to WR_AW_W with awvalid=wvalid=1 from N+1. Read: go to RD_AR with arvalid=1 from N+1.
//   WR_AW_W: awvalid drops on the edge of its own handshake; wvalid drops on the edge of its own handshake, independently.
//     AW and W may complete in the same cycle or in either order. When both are done -> WR_B, bready=1 on the next cycle.
//   WR_B: wait for bvalid; on handshake bready=0, capture err=bresp[1], rdata=0 -> RSP.
//   RD_AR: hold arvalid and araddr stable until arready; on handshake arvalid=0, rready=1 -> RD_R.
//   RD_R: on rvalid, capture rdata and err=rresp[1]; rready=0 -> RSP.
//   RSP: rsp_valid_o=1 with stable rdata/error until rsp_ready_i; on handshake rsp_valid_o=0 -> IDLE.
//     cmd_ready_o goes high the cycle after the handshake (no same-cycle command accept in RSP).
//  AXI rules: a valid is never withdrawn before its ready; addr/data stay stable while valid.
//   bready/rready are asserted only in WR_B/RD_R; early bvalid/rvalid in other states are ignored.
//  Minimum latency with zero-wait slave: write cmd at N -> AW/W handshake N+1 -> bready N+2 -> B handshake N+2 -> rsp_valid_o N+3.
//   Read: AR at N+1, R at N+2, rsp_valid_o at N+3.
//  EXOKAY (2'b01) is reported as non-error. Response contents stay unchanged until the next response.
// STRUCTURE
//  Shared include rv_axi_defs.vh: FSM state localparams (IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP), AXI resp codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
//  Single flat module with no sub-module; the response holding register is inline.
// TESTING (bench pairs this block with the existing AXI-Lite slave bridge and a behavioural slave)
//  1 Write addr 0x4, data 0xDEADBEEF; slave awready delayed 3 cycles, wready immediate -> wvalid drops first, awvalid held 3 cycles;
//    slave sees 0xDEADBEEF at 0x4 with wstrb=4'hF; rsp_valid_o with error=0, rdata=0.
//  2 Read addr 0x8; slave returns 0x12345678/OKAY after 2-cycle rvalid delay -> rsp_rdata_o=0x12345678, error=0; arvalid high exactly until arready.
//  3 Write with bresp=SLVERR, then read with rresp=DECERR -> rsp_error_o=1 for both; next OKAY read gives error=0.
//  4 rsp_ready_i held low 5 cycles -> rsp_valid_o/data stable, cmd_ready_o=0 throughout; back-to-back cmds with zero-wait slave -> rsp_valid_o at N+3 each.
//  5 Assert aresetn=0 during RD_R (rvalid not yet high) -> rready/arvalid/rsp_valid_o go 0 immediately; after release cmd_ready_o=1 and no stale response appears.

Source files
------------

// File: rtl/ready_valid_to_axi_master_pkg.sv
// Shared types and constants for the ready/valid to AXI4-Lite initiator.
package ready_valid_to_axi_master_pkg;

   // Transaction sequencer states
   typedef enum logic [2:0] {
      StIdle,
      StWrAwW,
      StWrB,
      StRdAr,
      StRdR,
      StRsp
   } state_e;

   // AXI response codes
   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespExOkay = 2'b01;
   localparam logic [1:0] RespSlvErr = 2'b10;
   localparam logic [1:0] RespDecErr = 2'b11;

   // EXOKAY counts as success; only SLVERR/DECERR are errors
   function automatic logic resp_is_err(input logic [1:0] resp);
      logic err;
      err = 1'b0;
      case (resp)
         RespOkay:   err = 1'b0;
         RespExOkay: err = 1'b0;
         RespSlvErr: err = 1'b1;
         RespDecErr: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/ready_valid_to_axi_master.sv
// AXI4-Lite initiator: one single-beat read or write per accepted command, result
// returned on a ready/valid response channel. At most one transaction in flight.
module ready_valid_to_axi_master
   import ready_valid_to_axi_master_pkg::*;
#(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 32
) (
   input  logic                M00_AXI_aclk,
   input  logic                M00_AXI_aresetn,
   // command channel
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic                cmd_write_i,
   input  logic [ADDR_W-1:0]   cmd_addr_i,
   input  logic [DATA_W-1:0]   cmd_wdata_i,
   // response channel
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [DATA_W-1:0]   rsp_rdata_o,
   output logic                rsp_error_o,
   // AXI write address
   output logic [ADDR_W-1:0]   M00_AXI_awaddr,
   output logic                M00_AXI_awvalid,
   input  logic                M00_AXI_awready,
   // AXI write data
   output logic [DATA_W-1:0]   M00_AXI_wdata,
   output logic [DATA_W/8-1:0] M00_AXI_wstrb,
   output logic                M00_AXI_wvalid,
   input  logic                M00_AXI_wready,
   // AXI write response
   input  logic [1:0]          M00_AXI_bresp,
   input  logic                M00_AXI_bvalid,
   output logic                M00_AXI_bready,
   // AXI read address
   output logic [ADDR_W-1:0]   M00_AXI_araddr,
   output logic                M00_AXI_arvalid,
   input  logic                M00_AXI_arready,
   // AXI read data
   input  logic [DATA_W-1:0]   M00_AXI_rdata,
   input  logic [1:0]          M00_AXI_rresp,
   input  logic                M00_AXI_rvalid,
   output logic                M00_AXI_rready
);

   localparam int unsigned StrbW = DATA_W / 8;

   state_e              state_q, state_d;
   logic                awvalid_q, awvalid_d;
   logic                wvalid_q, wvalid_d;
   logic                bready_q, bready_d;
   logic                arvalid_q, arvalid_d;
   logic                rready_q, rready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_error_q, rsp_error_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;

   // Next-state and registered-output computation for the transaction sequencer
   always_comb begin
      state_d     = state_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_error_d = rsp_error_q;
      rsp_rdata_d = rsp_rdata_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid_i) begin
               addr_d  = cmd_addr_i;
               wdata_d = cmd_wdata_i;
               if (cmd_write_i) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = StWrAwW;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = StRdAr;
               end
            end
         end
         StWrAwW: begin
            // AW and W retire independently; B phase starts once both are gone
            if (M00_AXI_awready) awvalid_d = 1'b0;
            if (M00_AXI_wready)  wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = StWrB;
            end
         end
         StWrB: begin
            if (M00_AXI_bvalid) begin
               bready_d    = 1'b0;
               rsp_error_d = resp_is_err(M00_AXI_bresp);
               rsp_rdata_d = '0;
               rsp_valid_d = 1'b1;
               state_d     = StRsp;
            end
         end
         StRdAr: begin
            if (M00_AXI_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = StRdR;
            end
         end
         StRdR: begin
            if (M00_AXI_rvalid) begin
               rready_d    = 1'b0;
               rsp_error_d = resp_is_err(M00_AXI_rresp);
               rsp_rdata_d = M00_AXI_rdata;
               rsp_valid_d = 1'b1;
               state_d     = StRsp;
            end
         end
         StRsp: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers; reset drops every valid and abandons the transaction
   always_ff @(posedge M00_AXI_aclk or negedge M00_AXI_aresetn) begin
      if (!M00_AXI_aresetn) begin
         state_q     <= StIdle;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_error_q <= rsp_error_d;
         rsp_rdata_q <= rsp_rdata_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
      end
   end

   // Gated by reset so no command is accepted while reset is held
   assign cmd_ready_o     = (state_q == StIdle) & M00_AXI_aresetn;

   assign rsp_valid_o     = rsp_valid_q;
   assign rsp_rdata_o     = rsp_rdata_q;
   assign rsp_error_o     = rsp_error_q;

   assign M00_AXI_awaddr  = addr_q;
   assign M00_AXI_awvalid = awvalid_q;
   assign M00_AXI_wdata   = wdata_q;
   assign M00_AXI_wstrb   = {StrbW{1'b1}};
   assign M00_AXI_wvalid  = wvalid_q;
   assign M00_AXI_bready  = bready_q;
   assign M00_AXI_araddr  = addr_q;
   assign M00_AXI_arvalid = arvalid_q;
   assign M00_AXI_rready  = rready_q;

endmodule

// File: tb/tb_ready_valid_to_axi_master.sv
// Bench for ready_valid_to_axi_master: behavioural AXI-Lite slave with per-transaction
// configurable delays/responses, plus a memory/latency reference model.
module tb_ready_valid_to_axi_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
   logic [3:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        cmd_ready, rsp_valid, rsp_error;
   logic [31:0] rsp_rdata;
   logic [3:0]  awaddr, araddr, wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [1:0]  bresp, rresp;

   ready_valid_to_axi_master #(.ADDR_W(4), .DATA_W(32)) dut (
      .M00_AXI_aclk(clk), .M00_AXI_aresetn(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
      .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
      .rsp_error_o(rsp_error),
      .M00_AXI_awaddr(awaddr), .M00_AXI_awvalid(awvalid), .M00_AXI_awready(awready),
      .M00_AXI_wdata(wdata), .M00_AXI_wstrb(wstrb), .M00_AXI_wvalid(wvalid),
      .M00_AXI_wready(wready),
      .M00_AXI_bresp(bresp), .M00_AXI_bvalid(bvalid), .M00_AXI_bready(bready),
      .M00_AXI_araddr(araddr), .M00_AXI_arvalid(arvalid), .M00_AXI_arready(arready),
      .M00_AXI_rdata(rdata), .M00_AXI_rresp(rresp), .M00_AXI_rvalid(rvalid),
      .M00_AXI_rready(rready)
   );

   // ---------------- behavioural slave ----------------
   int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   int          aw_wait, w_wait, b_wait, ar_wait, r_wait, aw_waits_seen, w_waits_seen;
   logic        aw_got, w_got, b_pend, r_pend;
   logic [3:0]  aw_a, r_a, w_s, last_strb;
   logic [31:0] w_d;
   logic [31:0] mem [16];

   assign awready = awvalid && (aw_wait >= aw_dly);
   assign wready  = wvalid && (w_wait >= w_dly);
   assign bvalid  = b_pend && (b_wait >= b_dly);
   assign bresp   = bresp_cfg;
   assign arready = arvalid && (ar_wait >= ar_dly);
   assign rvalid  = r_pend && (r_wait >= r_dly);
   assign rdata   = mem[r_a];
   assign rresp   = rresp_cfg;

   wire aw_hs = awvalid && awready;
   wire w_hs  = wvalid && wready;
   wire b_hs  = bvalid && bready;
   wire ar_hs = arvalid && arready;
   wire r_hs  = rvalid && rready;

   // Slave state; cleared together with the DUT by the system reset
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
         aw_a <= '0; r_a <= '0; w_s <= '0; w_d <= '0; last_strb <= '0;
         aw_waits_seen <= -1; w_waits_seen <= -1;
         for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
      end else begin
         aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
         w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
         ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
         if (aw_hs) begin aw_got <= 1'b1; aw_a <= awaddr; aw_waits_seen <= aw_wait; end
         if (w_hs) begin w_got <= 1'b1; w_d <= wdata; w_s <= wstrb; w_waits_seen <= w_wait; end
         if ((aw_got || aw_hs) && (w_got || w_hs) && !b_pend) begin
            mem[aw_hs ? awaddr : aw_a] <= w_hs ? wdata : w_d;
            last_strb <= w_hs ? wstrb : w_s;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_wait <= 0;
         end
         if (b_pend) begin
            if (b_hs) b_pend <= 1'b0;
            else b_wait <= b_wait + 1;
         end
         if (ar_hs) begin r_pend <= 1'b1; r_a <= araddr; r_wait <= 0; end
         if (r_pend) begin
            if (r_hs) r_pend <= 1'b0;
            else r_wait <= r_wait + 1;
         end
      end
   end

   // AXI stability monitor: a pending valid must stay high with a stable payload
   int          aw_viol = 0, w_viol = 0, ar_viol = 0;
   logic        aw_pm, w_pm, ar_pm;
   logic [3:0]  aw_pa, ar_pa;
   logic [31:0] w_pd;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_pm <= 1'b0; w_pm <= 1'b0; ar_pm <= 1'b0;
         aw_pa <= '0; ar_pa <= '0; w_pd <= '0;
      end else begin
         if (aw_pm && (!awvalid || awaddr != aw_pa)) aw_viol <= aw_viol + 1;
         if (w_pm && (!wvalid || wdata != w_pd)) w_viol <= w_viol + 1;
         if (ar_pm && (!arvalid || araddr != ar_pa)) ar_viol <= ar_viol + 1;
         aw_pm <= awvalid && !awready; aw_pa <= awaddr;
         w_pm  <= wvalid && !wready;   w_pd  <= wdata;
         ar_pm <= arvalid && !arready; ar_pa <= araddr;
      end
   end

   // ---------------- checking / reference model ----------------
   int          n_checks = 0, n_errors = 0;
   logic [31:0] exp_mem [16];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) exp_mem[i] = 32'hA5A5_0000 | 32'(i);
   endtask

   task automatic slave_cfg(input int aw, input int w, input int b, input int ar, input int r,
                            input logic [1:0] bre, input logic [1:0] rre);
      aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
      bresp_cfg = bre; rresp_cfg = rre;
   endtask

   // Issue one command, wait for its response, hold rsp_ready low for 'hold' cycles.
   // lat = number of falling edges from the command handshake edge to rsp_valid seen.
   task automatic do_cmd(input logic wr, input logic [3:0] a, input logic [31:0] d,
                         input int hold, output logic [31:0] rd, output logic er,
                         output int lat);
      int  t;
      bit  stable;
      rd = '0; er = 1'b0; lat = -1;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
      t = 0;
      while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
      if (!cmd_ready) begin
         check_eq("cmd_timeout", 32'd0, 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 300) begin @(negedge clk); lat++; end
      if (!rsp_valid) begin
         check_eq("rsp_timeout", 32'd0, 32'd1);
         lat = -1;
         return;
      end
      rd = rsp_rdata; er = rsp_error;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!rsp_valid || rsp_rdata !== rd || rsp_error !== er || cmd_ready) stable = 1'b0;
      end
      if (hold > 0) check_eq("rsp_stall_stable", 32'(stable), 32'd1);
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check_eq("rsp_dropped", 32'(rsp_valid), 32'd0);
      check_eq("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
   endtask

   // One transaction checked against the model: data, error, latency, memory effect
   task automatic txn(input logic wr, input logic [3:0] a, input logic [31:0] d, input int hold);
      logic [31:0] rd, exp_rd;
      logic        er, exp_er;
      int          lat, exp_lat;
      exp_rd  = wr ? 32'd0 : exp_mem[a];
      exp_er  = wr ? bresp_cfg[1] : rresp_cfg[1];
      exp_lat = wr ? (((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly + 3) : (ar_dly + r_dly + 3);
      do_cmd(wr, a, d, hold, rd, er, lat);
      check_eq(wr ? "wr_rdata" : "rd_rdata", rd, exp_rd);
      check_eq(wr ? "wr_error" : "rd_error", 32'(er), 32'(exp_er));
      check_eq(wr ? "wr_latency" : "rd_latency", 32'(lat), 32'(exp_lat));
      if (wr) begin
         exp_mem[a] = d;
         check_eq("slave_mem", mem[a], exp_mem[a]);
         check_eq("wstrb", 32'(last_strb), 32'hF);
      end
   endtask

   initial begin
      int  t;
      bit  saw;
      model_reset();
      // reset state
      repeat (3) @(negedge clk);
      check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("rst_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
      check_eq("rst_rsp", {rsp_rdata[30:0], rsp_valid} | 32'(rsp_error), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

      // 1: write with delayed awready, immediate wready
      slave_cfg(3, 0, 0, 0, 0, 2'b00, 2'b00);
      txn(1'b1, 4'h4, 32'hDEADBEEF, 0);
      check_eq("t1_aw_wait", 32'(aw_waits_seen), 32'd3);
      check_eq("t1_w_wait", 32'(w_waits_seen), 32'd0);

      // 2: read with rvalid delayed 2 cycles
      slave_cfg(0, 0, 0, 1, 2, 2'b00, 2'b00);
      exp_mem[8] = 32'h12345678;
      txn(1'b1, 4'h8, 32'h12345678, 0);
      txn(1'b0, 4'h8, 32'h0, 0);

      // 3: SLVERR write, DECERR read, EXOKAY read, OKAY read
      slave_cfg(0, 2, 1, 0, 0, 2'b10, 2'b11);
      txn(1'b1, 4'hC, 32'hCAFEF00D, 0);
      txn(1'b0, 4'hC, 32'h0, 0);
      slave_cfg(0, 0, 0, 0, 0, 2'b00, 2'b01);
      txn(1'b0, 4'h4, 32'h0, 0);
      slave_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00);
      txn(1'b0, 4'h4, 32'h0, 0);

      // 4: response stall, then back-to-back zero-wait commands
      txn(1'b0, 4'h8, 32'h0, 5);
      txn(1'b1, 4'h2, 32'h0BAD_CAFE, 0);
      txn(1'b0, 4'h2, 32'h0, 0);
      txn(1'b1, 4'h3, 32'h1357_9BDF, 0);

      // 5: reset while waiting for read data
      slave_cfg(0, 0, 0, 0, 40, 2'b00, 2'b00);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h8;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      t = 0;
      while (!rready && t < 50) begin @(negedge clk); t++; end
      check_eq("t5_in_rd_r", 32'(rready), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("t5_rready_drop", 32'(rready), 32'd0);
      check_eq("t5_arvalid_drop", 32'(arvalid), 32'd0);
      check_eq("t5_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("t5_cmd_ready_in_rst", 32'(cmd_ready), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      check_eq("t5_cmd_ready_after", 32'(cmd_ready), 32'd1);
      saw = 1'b0;
      repeat (20) begin @(negedge clk); if (rsp_valid) saw = 1'b1; end
      check_eq("t5_no_stale_rsp", 32'(saw), 32'd0);
      slave_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00);
      txn(1'b0, 4'h8, 32'h0, 0);

      // randomized traffic
      for (int n = 0; n < 60; n++) begin
         slave_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
             $urandom_range(0, 2));
      end

      check_eq("aw_stable", 32'(aw_viol), 32'd0);
      check_eq("w_stable", 32'(w_viol), 32'd0);
      check_eq("ar_stable", 32'(ar_viol), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
